// File: rtl/keypad_time_entry_pkg.sv
// Shared types and constants for the keypad time-entry block.
// Defining SECONDS_CLAMP_EN makes clampSeconds take effect in the top level.
package keypad_time_entry_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int          DIGIT_W = 4;
    localparam int          TIME_W  = 16;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    // Seconds-tens above 5 is not a real time; pull the seconds down to 59.
    function automatic logic [TIME_W-1:0] clampSeconds(input logic [TIME_W-1:0] t);
        if (t[7:4] > 4'd5) begin
            return {t[15:8], 8'h59};
        end
        return t;
    endfunction

endpackage

// File: rtl/keypad_time_entry_if.sv
// Timer-side handshake between the keypad time-entry block (master) and the countdown timer (slave).
interface keypad_time_entry_if;
    import keypad_time_entry_pkg::*;

    logic [TIME_W-1:0] time_bcd;
    logic              time_valid;
    logic              time_ready;
    logic              done;

    modport master (
        output time_bcd,
        output time_valid,
        input  time_ready,
        input  done
    );

    modport slave (
        input  time_bcd,
        input  time_valid,
        output time_ready,
        output done
    );

endinterface

// File: rtl/keypad_time_entry_sync.sv
// Synchronizes the encoder's loadn strobe and digit bus, and turns each loadn falling edge into a one-cycle key event.
module keypad_sync
    import keypad_time_entry_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] d_i,
    input  logic               loadn_i,
    output logic               key_evt_o,
    output logic [DIGIT_W-1:0] key_digit_o
);

    logic [SYNC_STAGES-1:0] loadnSync_q;
    logic [DIGIT_W-1:0]     dSync_q [SYNC_STAGES];
    logic                   loadnLast_q;

    // loadn idles high, so the chain resets to 1 and no edge appears out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            loadnSync_q <= '1;
            loadnLast_q <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dSync_q[i] <= '0;
            end
        end else begin
            loadnSync_q <= {loadnSync_q[SYNC_STAGES-2:0], loadn_i};
            loadnLast_q <= loadnSync_q[SYNC_STAGES-1];
            dSync_q[0]  <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dSync_q[i] <= dSync_q[i-1];
            end
        end
    end

    assign key_evt_o   = loadnLast_q & ~loadnSync_q[SYNC_STAGES-1];
    assign key_digit_o = dSync_q[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_time_entry.sv
// Assembles keypad BCD digits into an MM:SS cooking time, offers it to the timer and gates the keyboard.
// Optional feature macro: SECONDS_CLAMP_EN (clamp committed seconds above 59 to 59).
module keypad_time_entry
    import keypad_time_entry_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_DIGITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIGIT_W-1:0]   d_i,
    input  logic                 loadn_i,
    input  logic                 clear_i,
    input  logic                 commit_i,
    keypad_time_entry_if.master  tmr,
    output logic                 kbd_enablen_o,
    output logic [2:0]           digit_cnt_o,
    output logic                 key_err_o
);

    localparam logic [2:0] MaxCnt = 3'(MAX_DIGITS);

    state_t             state_q;
    logic [TIME_W-1:0]  timeBcd_q;
    logic [2:0]         digitCnt_q;
    logic               timeValid_q;
    logic               kbdEnablen_q;
    logic               keyErr_q;

    logic               keyEvt;
    logic [DIGIT_W-1:0] keyDigit;
    logic [TIME_W-1:0]  commitTime;

    keypad_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .d_i         (d_i),
        .loadn_i     (loadn_i),
        .key_evt_o   (keyEvt),
        .key_digit_o (keyDigit)
    );

`ifdef SECONDS_CLAMP_EN
    assign commitTime = clampSeconds(timeBcd_q);
`else
    assign commitTime = timeBcd_q;
`endif

    // clear outranks commit, and commit swallows a coincident key event without flagging it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timeBcd_q    <= '0;
            digitCnt_q   <= '0;
            timeValid_q  <= 1'b0;
            kbdEnablen_q <= 1'b0;
            keyErr_q     <= 1'b0;
        end else begin
            keyErr_q     <= 1'b0;
            kbdEnablen_q <= (state_q == COMMIT) || (state_q == LOCKED);
            if (clear_i) begin
                state_q     <= IDLE;
                timeBcd_q   <= '0;
                digitCnt_q  <= '0;
                timeValid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, ENTRY: begin
                        if (commit_i) begin
                            if (state_q == ENTRY) begin
                                state_q     <= COMMIT;
                                timeValid_q <= 1'b1;
                                timeBcd_q   <= commitTime;
                            end
                        end else if (keyEvt) begin
                            if ((keyDigit > BCD_MAX) || (digitCnt_q == MaxCnt)) begin
                                keyErr_q <= 1'b1;
                            end else begin
                                timeBcd_q  <= {timeBcd_q[TIME_W-DIGIT_W-1:0], keyDigit};
                                digitCnt_q <= digitCnt_q + 3'd1;
                                state_q    <= ENTRY;
                            end
                        end
                    end
                    COMMIT: begin
                        if (keyEvt && !commit_i) begin
                            keyErr_q <= 1'b1;
                        end
                        if (tmr.time_ready) begin
                            state_q     <= LOCKED;
                            timeValid_q <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (tmr.done) begin
                            state_q    <= IDLE;
                            timeBcd_q  <= '0;
                            digitCnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tmr.time_bcd   = timeBcd_q;
    assign tmr.time_valid = timeValid_q;
    assign kbd_enablen_o  = kbdEnablen_q;
    assign digit_cnt_o    = digitCnt_q;
    assign key_err_o      = keyErr_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Self-checking bench for keypad_time_entry: directed keypad sequences compared each cycle against an MM:SS entry model.
// Honours SECONDS_CLAMP_EN the same way the design does.
module tb_keypad_time_entry;
    import keypad_time_entry_pkg::*;

    localparam int SYNC     = 2;
    localparam int MAXD     = 4;
    localparam int P_IDLE   = 0;
    localparam int P_ENTRY  = 1;
    localparam int P_COMMIT = 2;
    localparam int P_LOCKED = 3;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] dIn    = 4'd0;
    logic       loadn  = 1'b1;
    logic       clear  = 1'b0;
    logic       commit = 1'b0;
    logic       kbdEnablen;
    logic [2:0] digitCnt;
    logic       keyErr;

    keypad_time_entry_if tmrIf ();

    int checkCount = 0;
    int passCount  = 0;
    int errPulses  = 0;
    int validCycles;
    bit checkEn    = 1'b0;

    int          mDigits[$];
    int          mPhase = P_IDLE;
    logic [15:0] mTime  = 16'h0;
    logic        mValid = 1'b0;
    logic        mKbd   = 1'b0;
    logic        mErr   = 1'b0;
    logic        hL [SYNC+1];
    logic [3:0]  hD [SYNC+1];

    keypad_time_entry #(
        .SYNC_STAGES (SYNC),
        .MAX_DIGITS  (MAXD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .d_i           (dIn),
        .loadn_i       (loadn),
        .clear_i       (clear),
        .commit_i      (commit),
        .tmr           (tmrIf),
        .kbd_enablen_o (kbdEnablen),
        .digit_cnt_o   (digitCnt),
        .key_err_o     (keyErr)
    );

    always #5 clk = ~clk;

    // Entered digits read as a right-aligned MM:SS number in base 16.
    function automatic logic [15:0] timeOf();
        int v = 0;
        foreach (mDigits[i]) v = v * 16 + mDigits[i];
        return 16'(v);
    endfunction

    function automatic logic [15:0] clampModel(input logic [15:0] t);
        logic [15:0] r = t;
`ifdef SECONDS_CLAMP_EN
        if (((int'(t) / 16) % 16) > 5) r = 16'((int'(t) / 256) * 256 + 'h59);
`endif
        return r;
    endfunction

    function automatic void modelIdle();
        mDigits.delete();
        mTime  = 16'h0;
        mValid = 1'b0;
        mPhase = P_IDLE;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    // A key counts at the edge that sees loadn low for the first time after SYNC sampling edges.
    always @(posedge clk) begin
        bit evt;
        int dig;
        int oldPhase;
        if (rst) begin
            modelIdle();
            mKbd = 1'b0;
            mErr = 1'b0;
            for (int i = 0; i <= SYNC; i++) begin
                hL[i] = 1'b1;
                hD[i] = 4'd0;
            end
        end else begin
            evt      = (hL[SYNC-1] == 1'b0) && (hL[SYNC] == 1'b1);
            dig      = int'(hD[SYNC-1]);
            oldPhase = mPhase;
            mErr     = 1'b0;
            mKbd     = (oldPhase == P_COMMIT) || (oldPhase == P_LOCKED);
            if (clear) begin
                modelIdle();
            end else if (oldPhase == P_IDLE || oldPhase == P_ENTRY) begin
                if (commit) begin
                    if (oldPhase == P_ENTRY) begin
                        mPhase = P_COMMIT;
                        mValid = 1'b1;
                        mTime  = clampModel(mTime);
                    end
                end else if (evt) begin
                    if (dig > 9 || mDigits.size() == MAXD) begin
                        mErr = 1'b1;
                    end else begin
                        mDigits.push_back(dig);
                        mTime  = timeOf();
                        mPhase = P_ENTRY;
                    end
                end
            end else if (oldPhase == P_COMMIT) begin
                if (evt && !commit) mErr = 1'b1;
                if (tmrIf.time_ready) begin
                    mPhase = P_LOCKED;
                    mValid = 1'b0;
                end
            end else if (tmrIf.done) begin
                modelIdle();
            end
            for (int i = SYNC; i > 0; i--) begin
                hL[i] = hL[i-1];
                hD[i] = hD[i-1];
            end
            hL[0] = loadn;
            hD[0] = dIn;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc time_bcd",    32'(tmrIf.time_bcd),   32'(mTime));
            checkOutput("cyc digit_cnt",   32'(digitCnt),         32'(mDigits.size()));
            checkOutput("cyc time_valid",  32'(tmrIf.time_valid), 32'(mValid));
            checkOutput("cyc kbd_enablen", 32'(kbdEnablen),       32'(mKbd));
            checkOutput("cyc key_err",     32'(keyErr),           32'(mErr));
        end
    end

    task automatic applyStimulus(input logic [3:0] dig);
        @(negedge clk);
        dIn   = dig;
        loadn = 1'b0;
        repeat (20) begin
            @(negedge clk);
            errPulses += int'(keyErr);
        end
        loadn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            errPulses += int'(keyErr);
        end
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulseCommit();
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    initial begin
        tmrIf.time_ready = 1'b0;
        tmrIf.done       = 1'b0;
        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset time_bcd",    32'(tmrIf.time_bcd),   32'h0);
        checkOutput("reset time_valid",  32'(tmrIf.time_valid), 32'h0);
        checkOutput("reset kbd_enablen", 32'(kbdEnablen),       32'h0);
        rst = 1'b0;

        $display("[TB] keys 1,3,0");
        applyStimulus(4'd1);
        checkOutput("t1 first shift", 32'(tmrIf.time_bcd), 32'h0001);
        applyStimulus(4'd3);
        checkOutput("t1 second shift", 32'(tmrIf.time_bcd), 32'h0013);
        applyStimulus(4'd0);
        checkOutput("t1 time_bcd",    32'(tmrIf.time_bcd), 32'h0130);
        checkOutput("t1 digit_cnt",   32'(digitCnt),       32'd3);
        checkOutput("t1 kbd_enablen", 32'(kbdEnablen),     32'd0);

        $display("[TB] keys 1..5 with full register");
        pulseClear();
        errPulses = 0;
        for (int k = 1; k <= 4; k++) applyStimulus(4'(k));
        checkOutput("t2 time_bcd",     32'(tmrIf.time_bcd), 32'h1234);
        checkOutput("t2 digit_cnt",    32'(digitCnt),       32'd4);
        checkOutput("t2 no early err", 32'(errPulses),      32'd0);
        applyStimulus(4'd5);
        checkOutput("t2 err pulses",   32'(errPulses),      32'd1);
        checkOutput("t2 time frozen",  32'(tmrIf.time_bcd), 32'h1234);

        $display("[TB] commit and handshake");
        pulseClear();
        applyStimulus(4'd0);
        applyStimulus(4'd1);
        applyStimulus(4'd3);
        applyStimulus(4'd0);
        pulseCommit();
        validCycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) checkOutput("t3 kbd after commit", 32'(kbdEnablen), 32'd1);
            if (i == 5) tmrIf.time_ready = 1'b1;
            validCycles += int'(tmrIf.time_valid);
            @(negedge clk);
        end
        tmrIf.time_ready = 1'b0;
        checkOutput("t3 valid cycles",  32'(validCycles),      32'd6);
        checkOutput("t3 valid dropped", 32'(tmrIf.time_valid), 32'd0);
        errPulses = 0;
        applyStimulus(4'd7);
        checkOutput("t3 locked time", 32'(tmrIf.time_bcd), 32'h0130);
        checkOutput("t3 locked err",  32'(errPulses),      32'd0);

        $display("[TB] done in LOCKED, clear in COMMIT");
        @(negedge clk);
        tmrIf.done = 1'b1;
        @(negedge clk);
        tmrIf.done = 1'b0;
        @(negedge clk);
        checkOutput("t4 done time", 32'(tmrIf.time_bcd), 32'h0);
        checkOutput("t4 done kbd",  32'(kbdEnablen),     32'd0);
        applyStimulus(4'd2);
        applyStimulus(4'd1);
        pulseCommit();
        repeat (2) @(negedge clk);
        pulseClear();
        checkOutput("t4 clear valid", 32'(tmrIf.time_valid), 32'd0);
        checkOutput("t4 clear time",  32'(tmrIf.time_bcd),   32'h0);
        checkOutput("t4 clear kbd",   32'(kbdEnablen),       32'd0);

        $display("[TB] coincident clear/commit with key");
        applyStimulus(4'd4);
        applyStimulus(4'd4);
        errPulses = 0;
        applyStimulus(4'hC);
        checkOutput("t5 bad digit err", 32'(errPulses), 32'd1);
        checkOutput("t5 bad digit cnt", 32'(digitCnt),  32'd2);
        @(negedge clk);
        dIn   = 4'd6;
        loadn = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (18) @(negedge clk);
        loadn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("t5 clear wins cnt",  32'(digitCnt),       32'd0);
        checkOutput("t5 clear wins time", 32'(tmrIf.time_bcd), 32'h0);
        applyStimulus(4'd5);
        applyStimulus(4'd5);
        errPulses = 0;
        @(negedge clk);
        dIn   = 4'd8;
        loadn = 1'b0;
        repeat (2) @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        checkOutput("t5 commit drop time", 32'(tmrIf.time_bcd), 32'h0055);
        repeat (18) begin
            @(negedge clk);
            errPulses += int'(keyErr);
        end
        loadn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("t5 commit drop err", 32'(errPulses), 32'd0);
        pulseClear();

        $display("[TB] seconds clamp and reset in COMMIT");
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        applyStimulus(4'd9);
        applyStimulus(4'd9);
        pulseCommit();
`ifdef SECONDS_CLAMP_EN
        checkOutput("t6 committed time", 32'(tmrIf.time_bcd), 32'h1259);
`else
        checkOutput("t6 committed time", 32'(tmrIf.time_bcd), 32'h1299);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6 rst time",  32'(tmrIf.time_bcd),   32'h0);
        checkOutput("t6 rst cnt",   32'(digitCnt),         32'd0);
        checkOutput("t6 rst valid", 32'(tmrIf.time_valid), 32'd0);
        checkOutput("t6 rst kbd",   32'(kbdEnablen),       32'd0);
        checkOutput("t6 rst err",   32'(keyErr),           32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
